// File: rtl/lp_coef_pkg.sv
// Shared definitions for the low-pass filter coefficient loader:
// the address map, the Q3.32 coefficient format and the FSM encoding.
package lp_coef_pkg;

    localparam int COEF_WIDTH = 35;

    localparam logic [2:0] ADDR_A1_L   = 3'd0;
    localparam logic [2:0] ADDR_A1_M   = 3'd1;
    localparam logic [2:0] ADDR_A1_H   = 3'd2;
    localparam logic [2:0] ADDR_B0_L   = 3'd3;
    localparam logic [2:0] ADDR_B0_M   = 3'd4;
    localparam logic [2:0] ADDR_B0_H   = 3'd5;
    localparam logic [2:0] ADDR_COMMIT = 3'd6;
    localparam logic [2:0] ADDR_CTRL   = 3'd7;

    // 1.0 in Q3.32
    localparam logic signed [COEF_WIDTH-1:0] Q_ONE = 35'sh1_0000_0000;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Stable pole: strictly inside (-1.0, +1.0)
    function automatic logic a1_in_range(input logic signed [COEF_WIDTH-1:0] a1);
        return (a1 < Q_ONE) && (a1 > -Q_ONE);
    endfunction

endpackage

// File: rtl/coef_stage.sv
// Staging register for one 35-bit coefficient, assembled from three
// 16-bit word writes (low, middle, top 3 bits).
module coef_stage
    import lp_coef_pkg::*;
#(
    parameter logic [2:0] ADDR_L = ADDR_A1_L,
    parameter logic [2:0] ADDR_M = ADDR_A1_M,
    parameter logic [2:0] ADDR_H = ADDR_A1_H
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  wr_stb_in,
    input  logic [2:0]            wr_addr_in,
    input  logic [15:0]           wr_data_in,
    output logic [COEF_WIDTH-1:0] coef_out
);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            coef_out <= '0;
        end else if (wr_stb_in) begin
            if (wr_addr_in == ADDR_L) begin
                coef_out[15:0] <= wr_data_in;
            end else if (wr_addr_in == ADDR_M) begin
                coef_out[31:16] <= wr_data_in;
            end else if (wr_addr_in == ADDR_H) begin
                coef_out[34:32] <= wr_data_in[2:0];
            end
        end
    end

endmodule

// File: rtl/lp_coef_loader.sv
// Host-side writer for the low-pass filter taps: stages a1/b0, applies them
// atomically on commit if a1 is stable, then optionally flushes the filter.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   RUN   | on_out follows enable_req
//   CLEAR | on_out held low while the counter runs down to 1
module lp_coef_loader #(
    parameter int CLEAR_CYCLES = 4,
    parameter int COEF_WIDTH   = 35
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         wr_stb_in,
    input  logic [2:0]                   wr_addr_in,
    input  logic [15:0]                  wr_data_in,
    output logic                         ack_out,
    output logic signed [COEF_WIDTH-1:0] a1_out,
    output logic signed [COEF_WIDTH-1:0] b0_out,
    output logic                         on_out,
    output logic                         err_out
);

    import lp_coef_pkg::*;

    localparam logic [7:0] CLR_LOAD = 8'(CLEAR_CYCLES);

    logic [COEF_WIDTH-1:0] a1_stage;
    logic [COEF_WIDTH-1:0] b0_stage;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic       enable_req, enable_nxt;
    logic       err_nxt;
    logic       on_nxt;
    logic       commit, ctrl, commit_ok;

    coef_stage #(
        .ADDR_L(ADDR_A1_L),
        .ADDR_M(ADDR_A1_M),
        .ADDR_H(ADDR_A1_H)
    ) u_a1_stage (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .wr_stb_in (wr_stb_in),
        .wr_addr_in(wr_addr_in),
        .wr_data_in(wr_data_in),
        .coef_out  (a1_stage)
    );

    coef_stage #(
        .ADDR_L(ADDR_B0_L),
        .ADDR_M(ADDR_B0_M),
        .ADDR_H(ADDR_B0_H)
    ) u_b0_stage (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .wr_stb_in (wr_stb_in),
        .wr_addr_in(wr_addr_in),
        .wr_data_in(wr_data_in),
        .coef_out  (b0_stage)
    );

    assign commit    = wr_stb_in && (wr_addr_in == ADDR_COMMIT);
    assign ctrl      = wr_stb_in && (wr_addr_in == ADDR_CTRL);
    assign commit_ok = commit && a1_in_range(a1_stage);

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enable_nxt = enable_req;
        err_nxt    = err_out;

        if (ctrl) begin
            enable_nxt = wr_data_in[0];
            if (wr_data_in[1]) begin
                err_nxt = 1'b0;
            end
        end
        if (commit && !commit_ok) begin
            err_nxt = 1'b1;
        end

        if (state == RUN) begin
            if (commit_ok && (CLEAR_CYCLES > 0)) begin
                state_nxt = CLEAR;
                cnt_nxt   = CLR_LOAD;
            end
        end else begin
            // A fresh commit restarts the flush from the full count
            if (commit_ok) begin
                cnt_nxt = CLR_LOAD;
            end else if (cnt <= 8'd1) begin
                state_nxt = RUN;
                cnt_nxt   = 8'd0;
            end else begin
                cnt_nxt = cnt - 8'd1;
            end
        end

        on_nxt = (state_nxt == RUN) && enable_nxt;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state      <= RUN;
            cnt        <= 8'd0;
            enable_req <= 1'b0;
            err_out    <= 1'b0;
            on_out     <= 1'b0;
            ack_out    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            enable_req <= enable_nxt;
            err_out    <= err_nxt;
            on_out     <= on_nxt;
            ack_out    <= wr_stb_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            a1_out <= '0;
            b0_out <= '0;
        end else if (commit_ok) begin
            a1_out <= a1_stage;
            b0_out <= b0_stage;
        end
    end

endmodule

// File: tb/tb_lp_coef_loader.sv
// Self-checking bench for lp_coef_loader: commit vector table, ack
// scoreboard, and hand-written flush/reset sequences.
module tb_lp_coef_loader;

    localparam int CLR = 4;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        wr_stb_in = 1'b0;
    logic [2:0]  wr_addr_in = 3'd0;
    logic [15:0] wr_data_in = 16'd0;

    logic               ack_out, on_out, err_out;
    logic signed [34:0] a1_out, b0_out;
    logic               ack0, on0, err0;
    logic signed [34:0] a10, b00;

    lp_coef_loader #(.CLEAR_CYCLES(CLR), .COEF_WIDTH(35)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .wr_stb_in (wr_stb_in),
        .wr_addr_in(wr_addr_in),
        .wr_data_in(wr_data_in),
        .ack_out   (ack_out),
        .a1_out    (a1_out),
        .b0_out    (b0_out),
        .on_out    (on_out),
        .err_out   (err_out)
    );

    lp_coef_loader #(.CLEAR_CYCLES(0), .COEF_WIDTH(35)) dut0 (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .wr_stb_in (wr_stb_in),
        .wr_addr_in(wr_addr_in),
        .wr_data_in(wr_data_in),
        .ack_out   (ack0),
        .a1_out    (a10),
        .b0_out    (b00),
        .on_out    (on0),
        .err_out   (err0)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int n_pass = 0;
    int n_chk  = 0;
    int ack_q[$];
    int e_cyc;

    typedef struct {
        logic [34:0] a1;
        logic [34:0] b0;
        logic        ok;
    } vec_t;
    vec_t vecs[6];

    logic [34:0] exp_a1, exp_b0;

    task automatic chk(input string name, input logic [34:0] act, input logic [34:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Scoreboard: each write pushes the cycle its ack is due in
    always @(negedge clk_in) begin
        if (ack_q.size() > 0 && ack_q[0] < cyc) begin
            n_chk++;
            $display("FAIL ack_missing: no ack in cycle %0d", ack_q[0]);
            void'(ack_q.pop_front());
        end
        if (ack_out) begin
            if (ack_q.size() == 0) begin
                n_chk++;
                $display("FAIL ack_unexpected: ack high in cycle %0d, none due", cyc);
            end else begin
                e_cyc = ack_q.pop_front();
                chk("ack_cycle", 35'(cyc), 35'(e_cyc));
            end
        end
    end

    task automatic drv(input logic [2:0] a, input logic [15:0] d);
        wr_stb_in  = 1'b1;
        wr_addr_in = a;
        wr_data_in = d;
        ack_q.push_back(cyc + 1);
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
        wr_stb_in = 1'b0;
    endtask

    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        drv(a, d);
        step();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic stage(input logic [34:0] a1, input logic [34:0] b0);
        logic [15:0] hi_a, hi_b;
        hi_a = {13'h1555, a1[34:32]};
        hi_b = {13'h0aaa, b0[34:32]};
        wr(3'd0, a1[15:0]);
        wr(3'd1, a1[31:16]);
        wr(3'd2, hi_a);
        wr(3'd3, b0[15:0]);
        wr(3'd4, b0[31:16]);
        wr(3'd5, hi_b);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{a1: 35'h1_0000_0000, b0: 35'h0_2000_0000, ok: 1'b0};
        vecs[1] = '{a1: 35'h7_0000_0000, b0: 35'h0_3000_0000, ok: 1'b0};
        vecs[2] = '{a1: 35'h7_0000_0001, b0: 35'h7_8000_0000, ok: 1'b1};
        vecs[3] = '{a1: 35'h0_FFFF_FFFF, b0: 35'h1_2345_6789, ok: 1'b1};
        vecs[4] = '{a1: 35'h4_0000_0000, b0: 35'h2_0000_0000, ok: 1'b0};
        vecs[5] = '{a1: 35'h3_FFFF_FFFF, b0: 35'h0_0000_0007, ok: 1'b0};

        // Reset
        rst_in = 1'b1;
        idle(3);
        rst_in = 1'b0;
        idle(1);
        @(negedge clk_in);
        chk("rst_a1", a1_out, 35'h0);
        chk("rst_b0", b0_out, 35'h0);
        chk("rst_on", 35'(on_out), 35'h0);
        chk("rst_err", 35'(err_out), 35'h0);
        chk("rst_ack", 35'(ack_out), 35'h0);
        idle(1);

        // Accepted commit, flush of CLR cycles
        stage(35'h0_F000_0000, 35'h0_1000_0000);
        wr(3'd7, 16'h0001);
        @(negedge clk_in);
        chk("on_before_commit", 35'(on_out), 35'h1);
        chk("stage_isolated_a1", a1_out, 35'h0);
        idle(1);
        drv(3'd6, 16'h0000);
        step();
        exp_a1 = 35'h0_F000_0000;
        exp_b0 = 35'h0_1000_0000;
        for (int i = 1; i <= CLR + 1; i++) begin
            @(negedge clk_in);
            chk("on_flush", 35'(on_out), 35'(i > CLR));
            chk("on_noflush", 35'(on0), 35'h1);
            if (i == 1) begin
                chk("commit_a1", a1_out, exp_a1);
                chk("commit_b0", b0_out, exp_b0);
                chk("commit0_a1", a10, exp_a1);
            end
        end
        idle(1);

        // Commit vector table: range limits on a1
        for (int i = 0; i < 6; i++) begin
            stage(vecs[i].a1, vecs[i].b0);
            wr(3'd6, 16'hffff);
            @(negedge clk_in);
            if (vecs[i].ok) begin
                exp_a1 = vecs[i].a1;
                exp_b0 = vecs[i].b0;
            end
            chk("vec_a1", a1_out, exp_a1);
            chk("vec_b0", b0_out, exp_b0);
            chk("vec_err", 35'(err_out), 35'(!vecs[i].ok));
            chk("vec_on", 35'(on_out), 35'(!vecs[i].ok));
            idle(CLR + 1);
            if (!vecs[i].ok) begin
                wr(3'd7, 16'h0003);
                @(negedge clk_in);
                chk("err_clear", 35'(err_out), 35'h0);
                chk("err_clear_on", 35'(on_out), 35'h1);
                idle(1);
            end
        end

        // Commit during CLEAR restarts the flush
        stage(35'h0_1234_5678, 35'h7_FFFF_FFFF);
        drv(3'd6, 16'h0000);
        step();
        drv(3'd0, 16'hAAAA);
        @(negedge clk_in);
        chk("first_commit_a1", a1_out, 35'h0_1234_5678);
        chk("first_commit_on", 35'(on_out), 35'h0);
        step();
        drv(3'd6, 16'h0000);
        step();
        for (int i = 1; i <= CLR + 1; i++) begin
            @(negedge clk_in);
            chk("reclear_on", 35'(on_out), 35'(i > CLR));
            if (i == 1) begin
                chk("second_commit_a1", a1_out, 35'h0_1234_AAAA);
                chk("second_commit_b0", b0_out, 35'h7_FFFF_FFFF);
            end
        end
        idle(1);

        // Reset in the middle of a flush, with err set
        stage(35'h1_0000_0000, 35'h0_0000_0005);
        wr(3'd6, 16'h0000);
        stage(35'h0_0000_0001, 35'h0_0000_0005);
        wr(3'd6, 16'h0000);
        idle(1);
        rst_in = 1'b1;
        idle(1);
        @(negedge clk_in);
        chk("midrst_a1", a1_out, 35'h0);
        chk("midrst_b0", b0_out, 35'h0);
        chk("midrst_on", 35'(on_out), 35'h0);
        chk("midrst_err", 35'(err_out), 35'h0);
        chk("midrst_ack", 35'(ack_out), 35'h0);
        chk("midrst0_a1", a10, 35'h0);
        idle(1);
        rst_in = 1'b0;
        idle(CLR + 2);
        @(negedge clk_in);
        chk("post_rst_on", 35'(on_out), 35'h0);
        idle(1);
        wr(3'd7, 16'h0001);
        @(negedge clk_in);
        chk("post_rst_enable", 35'(on_out), 35'h1);

        idle(3);
        chk("ack_queue_empty", 35'(ack_q.size()), 35'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
